// File: rtl/clkctl_pkg.sv
// Shared constants for the clock digit-chain controller: digit limits, mode and FSM encodings, timing.
// Pure definitions; no logic, no latency, no flow control.
package clkctl_pkg;

  // Digit maxima packed LSB-first: sec units, sec tens, min units, min tens.
  localparam logic [15:0] DIG_MAX_VEC = {4'd5, 4'd9, 4'd5, 4'd9};

  localparam logic [1:0] MODE_RUN     = 2'b00;
  localparam logic [1:0] MODE_SET_MIN = 2'b01;
  localparam logic [1:0] MODE_SET_SEC = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_CMD    = 2'b01;
  localparam logic [1:0] ST_SETTLE = 2'b10;

  localparam int CMD_HOLD   = 4;
  localparam int SETTLE_LEN = 2;

  typedef struct packed {
    logic [1:0] lo;
    logic [1:0] hi;
    logic       clr;
  } job_t;

  function automatic logic [3:0] dig_max(input int idx);
    return DIG_MAX_VEC[4*idx +: 4];
  endfunction

endpackage

// File: rtl/digit_carry_plan.sv
// Combinational carry planner: digit values and job range -> per-digit load/increment vectors.
// Zero latency; no flow control.
module digit_carry_plan
  import clkctl_pkg::*;
(
  input  logic [15:0] digits_i,
  input  job_t        job_i,
  output logic [3:0]  load_o,
  output logic [3:0]  up_o
);

  always_comb begin
    logic carry;
    load_o = '0;
    up_o   = '0;
    carry  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (job_i.clr) begin
        load_o[i] = 1'b1;
      end else if (2'(i) >= job_i.lo && 2'(i) <= job_i.hi && carry) begin
        // A digit at its maximum wraps to zero and passes the carry upward.
        if (digits_i[4*i +: 4] == dig_max(i)) begin
          load_o[i] = 1'b1;
        end else begin
          up_o[i] = 1'b1;
          carry   = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/digit_chain_ctrl.sv
// Clock digit-chain command controller: turns ticks/buttons into per-digit load/increment strobes.
// Strobes appear the cycle after a job is accepted; while busy one tick is queued, buttons are dropped.
module digit_chain_ctrl
  import clkctl_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       tick_1hz_i,
  input  logic       btn_mode_i,
  input  logic       btn_inc_i,
  input  logic       btn_clr_i,
  input  logic [3:0] cnt0_i,
  input  logic [3:0] cnt1_i,
  input  logic [3:0] cnt2_i,
  input  logic [3:0] cnt3_i,
  output logic [3:0] dig_clken_o,
  output logic [3:0] dig_loaden_o,
  output logic [3:0] dig_up_o,
  output logic [3:0] dig_load_o,
  output logic [1:0] mode_o,
  output logic       busy_o,
  output logic       blink_o,
  output logic       tick_lost_o
);

  logic [1:0] state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] mode_q, mode_d;
  logic       pend_q, pend_d;
  logic       lost_q, lost_d;
  logic       blink_q, blink_d;
  logic [3:0] clken_q, clken_d;
  logic [3:0] loaden_q, loaden_d;
  logic [3:0] up_q, up_d;

  job_t       job;
  logic       go;
  logic [3:0] plan_load, plan_up;

  digit_carry_plan u_plan (
    .digits_i ({cnt3_i, cnt2_i, cnt1_i, cnt0_i}),
    .job_i    (job),
    .load_o   (plan_load),
    .up_o     (plan_up)
  );

  always_comb begin
    go  = 1'b0;
    job = '{lo: 2'd0, hi: 2'd3, clr: 1'b0};
    // Job selection always uses the mode in force before any same-cycle mode press.
    if (state_q == ST_IDLE) begin
      if (mode_q == MODE_RUN) begin
        go = tick_1hz_i | pend_q;
      end else if (btn_clr_i) begin
        go      = 1'b1;
        job.clr = 1'b1;
      end else if (btn_inc_i) begin
        go     = 1'b1;
        job.lo = (mode_q == MODE_SET_MIN) ? 2'd2 : 2'd0;
        job.hi = (mode_q == MODE_SET_MIN) ? 2'd3 : 2'd1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    pend_d   = pend_q;
    lost_d   = lost_q;
    blink_d  = blink_q;
    clken_d  = clken_q;
    loaden_d = loaden_q;
    up_d     = up_q;

    if (mode_q == MODE_RUN) begin
      if (state_q == ST_IDLE) begin
        pend_d = pend_q & tick_1hz_i;
      end else if (tick_1hz_i) begin
        if (pend_q) lost_d = 1'b1;
        else        pend_d = 1'b1;
      end
    end

    if (btn_mode_i) begin
      case (mode_q)
        MODE_RUN:     mode_d = MODE_SET_MIN;
        MODE_SET_MIN: mode_d = MODE_SET_SEC;
        default:      mode_d = MODE_RUN;
      endcase
      if (mode_q == MODE_RUN) pend_d = 1'b0;
    end

    if (mode_d == MODE_RUN)                   blink_d = 1'b0;
    else if (tick_1hz_i && mode_q != MODE_RUN) blink_d = ~blink_q;

    case (state_q)
      ST_IDLE: begin
        if (go) begin
          state_d  = ST_CMD;
          cnt_d    = 2'd0;
          clken_d  = plan_load | plan_up;
          loaden_d = plan_load;
          up_d     = plan_up;
        end
      end
      ST_CMD: begin
        clken_d = '0;
        if (cnt_q == 2'(CMD_HOLD - 1)) begin
          state_d  = ST_SETTLE;
          cnt_d    = 2'd0;
          loaden_d = '0;
          up_d     = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        if (cnt_q == 2'(SETTLE_LEN - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      mode_q   <= MODE_RUN;
      pend_q   <= 1'b0;
      lost_q   <= 1'b0;
      blink_q  <= 1'b0;
      clken_q  <= '0;
      loaden_q <= '0;
      up_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      pend_q   <= pend_d;
      lost_q   <= lost_d;
      blink_q  <= blink_d;
      clken_q  <= clken_d;
      loaden_q <= loaden_d;
      up_q     <= up_d;
    end
  end

  assign dig_clken_o  = clken_q;
  assign dig_loaden_o = loaden_q;
  assign dig_up_o     = up_q;
  assign dig_load_o   = 4'b0000;
  assign mode_o       = mode_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign blink_o      = blink_q;
  assign tick_lost_o  = lost_q;

endmodule

// File: tb/tb_digit_chain_ctrl.sv
// Directed bench for digit_chain_ctrl: tick carries, back-to-back ticks, set modes, reset abort.
module tb_digit_chain_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick, bmode, binc, bclr;
  logic [3:0] c0, c1, c2, c3;
  logic [3:0] clken, loaden, up, load;
  logic [1:0] mode;
  logic       busy, blink, lost;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  digit_chain_ctrl dut (
    .clk_i        (clk),
    .reset_ni     (reset_n),
    .tick_1hz_i   (tick),
    .btn_mode_i   (bmode),
    .btn_inc_i    (binc),
    .btn_clr_i    (bclr),
    .cnt0_i       (c0),
    .cnt1_i       (c1),
    .cnt2_i       (c2),
    .cnt3_i       (c3),
    .dig_clken_o  (clken),
    .dig_loaden_o (loaden),
    .dig_up_o     (up),
    .dig_load_o   (load),
    .mode_o       (mode),
    .busy_o       (busy),
    .blink_o      (blink),
    .tick_lost_o  (lost)
  );

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input logic [3:0] m10, input logic [3:0] m1,
                            input logic [3:0] s10, input logic [3:0] s1);
    c3 = m10; c2 = m1; c1 = s10; c0 = s1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL wait_idle busy=%b required=0 after %0d cycles", busy, n);
    end
  endtask

  task automatic test_reset();
    tick = 0; bmode = 0; binc = 0; bclr = 0;
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    reset_n = 1'b0;
    step();
    checks++;
    if ({clken, loaden, up, load, mode, busy, blink, lost} !== 19'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b required=0", {clken, loaden, up, load, mode, busy, blink, lost});
    end
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_tick_units();
    set_digits(4'd0, 4'd0, 4'd0, 4'd8);
    tick = 1; step(); tick = 0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (clken !== ((c == 0) ? 4'b0001 : 4'b0000) || up !== 4'b0001 || loaden !== 4'b0000 || busy !== 1'b1) begin
        failures++;
        $display("FAIL units_cmd%0d clken=%b up=%b loaden=%b busy=%b required clken=%b up=0001 loaden=0000 busy=1",
                 c, clken, up, loaden, busy, (c == 0) ? 4'b0001 : 4'b0000);
      end
      step();
    end
    for (int c = 0; c < 2; c++) begin
      checks++;
      if (busy !== 1'b1 || {clken, loaden, up} !== 12'd0) begin
        failures++;
        $display("FAIL units_settle%0d busy=%b strobes=%b required busy=1 strobes=0", c, busy, {clken, loaden, up});
      end
      step();
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL units_busy_len busy=%b after 6 cycles required=0", busy);
    end
  endtask

  task automatic test_tick_carry();
    logic [3:0] exp_ck [3];
    logic [3:0] exp_ld [3];
    logic [3:0] exp_up [3];
    logic [15:0] digs [3];
    digs[0] = 16'h0859; exp_ck[0] = 4'b0111; exp_ld[0] = 4'b0011; exp_up[0] = 4'b0100;
    digs[1] = 16'h0959; exp_ck[1] = 4'b1111; exp_ld[1] = 4'b0111; exp_up[1] = 4'b1000;
    digs[2] = 16'h5959; exp_ck[2] = 4'b1111; exp_ld[2] = 4'b1111; exp_up[2] = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      set_digits(digs[k][15:12], digs[k][11:8], digs[k][7:4], digs[k][3:0]);
      tick = 1; step(); tick = 0;
      checks++;
      if (clken !== exp_ck[k] || loaden !== exp_ld[k] || up !== exp_up[k]) begin
        failures++;
        $display("FAIL carry_%h clken=%b loaden=%b up=%b required %b %b %b",
                 digs[k], clken, loaden, up, exp_ck[k], exp_ld[k], exp_up[k]);
      end
      step(); step(); step();
      checks++;
      if (clken !== 4'b0000 || loaden !== exp_ld[k] || up !== exp_up[k]) begin
        failures++;
        $display("FAIL carry_hold_%h clken=%b loaden=%b up=%b required 0000 %b %b",
                 digs[k], clken, loaden, up, exp_ld[k], exp_up[k]);
      end
      wait_idle();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_digits(4'd0, 4'd0, 4'd0, 4'd0);
    tick = 1; step(); step(); step(); tick = 0;
    checks++;
    if (lost !== 1'b1) begin
      failures++;
      $display("FAIL b2b_tick_lost got=%b required=1", lost);
    end
    wait_idle();
    step();
    checks++;
    if (busy !== 1'b1 || clken !== 4'b0001 || up !== 4'b0001) begin
      failures++;
      $display("FAIL b2b_second_job busy=%b clken=%b up=%b required 1 0001 0001", busy, clken, up);
    end
    wait_idle();
    step(); step(); step();
    checks++;
    if (busy !== 1'b0 || lost !== 1'b1) begin
      failures++;
      $display("FAIL b2b_no_third busy=%b lost=%b required busy=0 lost=1", busy, lost);
    end
  endtask

  task automatic test_set_sec();
    do_reset();
    bmode = 1; step(); step(); bmode = 0;
    checks++;
    if (mode !== 2'b10) begin
      failures++;
      $display("FAIL setsec_mode got=%b required=10", mode);
    end
    set_digits(4'd1, 4'd2, 4'd5, 4'd9);
    binc = 1; step(); binc = 0;
    checks++;
    if (clken !== 4'b0011 || loaden !== 4'b0011 || up !== 4'b0000) begin
      failures++;
      $display("FAIL setsec_inc clken=%b loaden=%b up=%b required 0011 0011 0000", clken, loaden, up);
    end
    binc = 1; step(); binc = 0;
    wait_idle();
    step(); step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL setsec_inc_ignored busy=%b required=0", busy);
    end
    tick = 1; step(); tick = 0;
    checks++;
    if (blink !== 1'b1 || busy !== 1'b0 || {clken, loaden, up} !== 12'd0) begin
      failures++;
      $display("FAIL setsec_tick blink=%b busy=%b strobes=%b required blink=1 busy=0 strobes=0",
               blink, busy, {clken, loaden, up});
    end
    bmode = 1; step(); bmode = 0;
    checks++;
    if (mode !== 2'b00 || blink !== 1'b0) begin
      failures++;
      $display("FAIL setsec_to_run mode=%b blink=%b required 00 0", mode, blink);
    end
  endtask

  task automatic test_set_min();
    do_reset();
    bmode = 1; step(); bmode = 0;
    set_digits(4'd5, 4'd9, 4'd3, 4'd0);
    binc = 1; step(); binc = 0;
    checks++;
    if (clken !== 4'b1100 || loaden !== 4'b1100 || up !== 4'b0000 || mode !== 2'b01) begin
      failures++;
      $display("FAIL setmin_inc clken=%b loaden=%b up=%b mode=%b required 1100 1100 0000 01",
               clken, loaden, up, mode);
    end
    wait_idle();
  endtask

  task automatic test_clr_reset();
    do_reset();
    bmode = 1; step(); bmode = 0;
    set_digits(4'd2, 4'd3, 4'd4, 4'd5);
    bclr = 1; binc = 1; step(); bclr = 0; binc = 0;
    checks++;
    if (clken !== 4'b1111 || loaden !== 4'b1111 || up !== 4'b0000) begin
      failures++;
      $display("FAIL clr_job clken=%b loaden=%b up=%b required 1111 1111 0000", clken, loaden, up);
    end
    step();
    reset_n = 1'b0;
    step();
    checks++;
    if ({clken, loaden, up, mode, busy, blink, lost} !== 17'd0) begin
      failures++;
      $display("FAIL clr_reset_abort got=%b required=0", {clken, loaden, up, mode, busy, blink, lost});
    end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_tick_units();
    test_tick_carry();
    test_back_to_back();
    test_set_sec();
    test_set_min();
    test_clr_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
